// File: rtl/transport_pkg.sv
// Shared types and helpers for the record/playback transport controller.
package transport_pkg;

    // Wide enough for any factor up to 16; ports narrow this to SPD_W.
    localparam int SPD_MAX_W = 4;

    typedef enum logic [2:0] {
        ST_P_STOP  = 3'b000,
        ST_P_PLAY  = 3'b010,
        ST_P_PAUSE = 3'b011,
        ST_R_STOP  = 3'b100,
        ST_INIT    = 3'b101,
        ST_R_REC   = 3'b110,
        ST_R_PAUSE = 3'b111
    } state_t;

    typedef struct packed {
        logic                 fast;
        logic [SPD_MAX_W-1:0] mag;
    } speed_t;

    localparam speed_t                SPEED_X1 = '0;
    localparam logic [SPD_MAX_W-1:0]  MAG_ONE  = SPD_MAX_W'(1);

    // Speed moves one step along a line slow(max)..x1..fast(max); simultaneous keys cancel.
    function automatic speed_t next_speed(
        input speed_t      cur,
        input logic        fast,
        input logic        slow,
        input int unsigned max_factor
    );
        speed_t               nxt;
        logic [SPD_MAX_W-1:0] mag_max;
        nxt     = cur;
        mag_max = SPD_MAX_W'(max_factor - 1);
        if (fast && !slow) begin
            if (cur.mag == '0) begin
                nxt.fast = 1'b1;
                nxt.mag  = MAG_ONE;
            end else if (!cur.fast) begin
                nxt.mag = cur.mag - MAG_ONE;
            end else if (cur.mag < mag_max) begin
                nxt.mag = cur.mag + MAG_ONE;
            end
        end else if (slow && !fast) begin
            if (cur.mag == '0) begin
                nxt.fast = 1'b0;
                nxt.mag  = MAG_ONE;
            end else if (cur.fast) begin
                nxt.mag = cur.mag - MAG_ONE;
            end else if (cur.mag < mag_max) begin
                nxt.mag = cur.mag + MAG_ONE;
            end
        end
        if (nxt.mag == '0) begin
            nxt.fast = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/transport_ctrl_play_addr_gen.sv
// Speed-aware playback read-address and repeat-phase stepper with end-of-recording detection.
module play_addr_gen #(
    parameter int ADDR_W = 20,
    parameter int SPD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              step,
    input  logic              fast,
    input  logic [SPD_W-1:0]  mag,
    input  logic [ADDR_W:0]   rec_len,
    output logic [ADDR_W-1:0] addr,
    output logic [SPD_W-1:0]  phase,
    output logic              done
);

    logic [ADDR_W:0] addr_inc;
    logic [ADDR_W:0] addr_next;
    logic            advance;

    // In slow mode a word is repeated mag+1 times before the address moves on.
    // Using >= keeps the phase bounded if the slow factor drops mid-repeat.
    always_comb begin
        advance   = fast || (mag == '0) || (phase >= mag);
        addr_inc  = fast ? ((ADDR_W+1)'(mag) + (ADDR_W+1)'(1)) : (ADDR_W+1)'(1);
        addr_next = {1'b0, addr} + (advance ? addr_inc : '0);
    end

    assign done = step && (addr_next >= rec_len);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            addr  <= '0;
            phase <= '0;
        end else if (step) begin
            if (done) begin
                addr  <= '0;
                phase <= '0;
            end else if (advance) begin
                addr  <= addr_next[ADDR_W-1:0];
                phase <= '0;
            end else begin
                phase <= phase + SPD_W'(1);
            end
        end
    end

endmodule

// File: rtl/transport_ctrl.sv
// Record/playback transport controller: transport FSM, play speed register,
// record address/length tracking and playback address generation.
//   state      | meaning
//   ST_INIT    | waiting for codec init to finish
//   ST_P_STOP  | play side idle, speed selectable
//   ST_P_PLAY  | issuing read addresses on DSP requests
//   ST_P_PAUSE | playback position held
//   ST_R_STOP  | record side idle
//   ST_R_REC   | writing accepted samples to SRAM
//   ST_R_PAUSE | record position held
module transport_ctrl
    import transport_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int MAX_FACTOR = 8,
    parameter int SPD_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_done,
    input  logic              i_mode,
    input  logic              i_play_rec,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow,
    input  logic              i_rec_valid,
    input  logic              i_play_req,
    output logic [2:0]        o_state,
    output logic              o_speed_fast,
    output logic [SPD_W-1:0]  o_speed_mag,
    output logic [ADDR_W-1:0] o_rec_addr,
    output logic              o_rec_we,
    output logic [ADDR_W-1:0] o_play_addr,
    output logic              o_play_addr_valid,
    output logic [SPD_W-1:0]  o_play_phase,
    output logic [ADDR_W:0]   o_rec_len,
    output logic              o_full,
    output logic              o_play_done
);

    state_t            state;
    state_t            state_nxt;
    speed_t            speed;
    speed_t            speed_nxt;
    speed_t            speed_key;
    logic [ADDR_W-1:0] rec_addr;
    logic [ADDR_W-1:0] rec_addr_nxt;
    logic [ADDR_W:0]   rec_len;
    logic [ADDR_W:0]   rec_len_nxt;
    logic [ADDR_W:0]   rec_len_wr;
    logic              rec_full;
    logic              play_step;
    logic              play_clr;
    logic              play_done;

    assign o_rec_we  = i_rst_n && (state == ST_R_REC) && i_rec_valid;
    assign rec_full  = o_rec_we && (&rec_addr);
    assign play_step = i_rst_n && (state == ST_P_PLAY) && i_play_req;
    assign play_clr  = i_stop && (state != ST_INIT);
    assign speed_key = next_speed(speed, i_fast, i_slow, MAX_FACTOR);

    // A word written in the cycle recording ends still counts toward the length.
    assign rec_len_wr = {1'b0, rec_addr} + (ADDR_W+1)'(o_rec_we);

    always_comb begin
        state_nxt    = state;
        speed_nxt    = speed;
        rec_addr_nxt = rec_addr;
        rec_len_nxt  = rec_len;
        case (state)
            ST_INIT: begin
                if (i_init_done) begin
                    state_nxt = i_mode ? ST_R_STOP : ST_P_STOP;
                end
            end
            ST_P_STOP: begin
                if (i_mode) begin
                    state_nxt = ST_R_STOP;
                end else if (!i_stop) begin
                    if (i_play_rec) begin
                        if (rec_len != '0) begin
                            state_nxt = ST_P_PLAY;
                        end
                    end else begin
                        speed_nxt = speed_key;
                    end
                end
            end
            ST_P_PLAY: begin
                if (i_stop || play_done) begin
                    state_nxt = ST_P_STOP;
                end else if (i_play_rec) begin
                    state_nxt = ST_P_PAUSE;
                end else begin
                    speed_nxt = speed_key;
                end
            end
            ST_P_PAUSE: begin
                if (i_stop) begin
                    state_nxt = ST_P_STOP;
                end else if (i_play_rec) begin
                    state_nxt = ST_P_PLAY;
                end else begin
                    speed_nxt = speed_key;
                end
            end
            ST_R_STOP: begin
                if (!i_mode) begin
                    state_nxt = ST_P_STOP;
                end else if (!i_stop && i_play_rec) begin
                    state_nxt = ST_R_REC;
                end
            end
            ST_R_REC: begin
                if (rec_full || i_stop) begin
                    state_nxt    = ST_R_STOP;
                    rec_len_nxt  = rec_len_wr;
                    rec_addr_nxt = '0;
                end else begin
                    if (o_rec_we) begin
                        rec_addr_nxt = rec_addr + ADDR_W'(1);
                    end
                    if (i_play_rec) begin
                        state_nxt = ST_R_PAUSE;
                    end
                end
            end
            ST_R_PAUSE: begin
                if (i_stop) begin
                    state_nxt    = ST_R_STOP;
                    rec_len_nxt  = {1'b0, rec_addr};
                    rec_addr_nxt = '0;
                end else if (i_play_rec) begin
                    state_nxt = ST_R_REC;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
        // Bit 2 set covers INIT and every record-side state.
        if (state_nxt[2] || ((state_nxt == ST_P_STOP) && (state != ST_P_STOP))) begin
            speed_nxt = SPEED_X1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_INIT;
            speed    <= SPEED_X1;
            rec_addr <= '0;
            rec_len  <= '0;
        end else begin
            state    <= state_nxt;
            speed    <= speed_nxt;
            rec_addr <= rec_addr_nxt;
            rec_len  <= rec_len_nxt;
        end
    end

    play_addr_gen #(
        .ADDR_W (ADDR_W),
        .SPD_W  (SPD_W)
    ) u_play_addr_gen (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clr     (play_clr),
        .step    (play_step),
        .fast    (speed.fast),
        .mag     (SPD_W'(speed.mag)),
        .rec_len (rec_len),
        .addr    (o_play_addr),
        .phase   (o_play_phase),
        .done    (play_done)
    );

    assign o_state           = state;
    assign o_speed_fast      = speed.fast;
    assign o_speed_mag       = SPD_W'(speed.mag);
    assign o_rec_addr        = rec_addr;
    assign o_rec_len         = rec_len;
    assign o_play_addr_valid = play_step;
    assign o_full            = rec_full;
    assign o_play_done       = play_done;

endmodule

// File: tb/tb_transport_ctrl.sv
// Directed and randomized bench for transport_ctrl against an integer-level transport model.
module tb_transport_ctrl;

    localparam int AW    = 4;
    localparam int MF    = 8;
    localparam int SW    = 4;
    localparam int DEPTH = 1 << AW;

    localparam int C_PSTOP = 0, C_PPLAY = 2, C_PPAUSE = 3, C_RSTOP = 4,
                   C_INIT = 5, C_RREC = 6, C_RPAUSE = 7;

    logic          clk = 1'b0;
    logic          rst_n, init_done, mode, play_rec, stop, fast, slow, rec_valid, play_req;
    logic [2:0]    o_state;
    logic          o_speed_fast, o_rec_we, o_play_addr_valid, o_full, o_play_done;
    logic [SW-1:0] o_speed_mag, o_play_phase;
    logic [AW-1:0] o_rec_addr, o_play_addr;
    logic [AW:0]   o_rec_len;

    transport_ctrl #(.ADDR_W(AW), .MAX_FACTOR(MF), .SPD_W(SW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_init_done       (init_done),
        .i_mode            (mode),
        .i_play_rec        (play_rec),
        .i_stop            (stop),
        .i_fast            (fast),
        .i_slow            (slow),
        .i_rec_valid       (rec_valid),
        .i_play_req        (play_req),
        .o_state           (o_state),
        .o_speed_fast      (o_speed_fast),
        .o_speed_mag       (o_speed_mag),
        .o_rec_addr        (o_rec_addr),
        .o_rec_we          (o_rec_we),
        .o_play_addr       (o_play_addr),
        .o_play_addr_valid (o_play_addr_valid),
        .o_play_phase      (o_play_phase),
        .o_rec_len         (o_rec_len),
        .o_full            (o_full),
        .o_play_done       (o_play_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: speed is a signed step count (+k = x(k+1), -k = x1/(k+1)); addresses are plain integers.
    int m_st = C_INIT, m_spd = 0, m_raddr = 0, m_rlen = 0, m_paddr = 0, m_ph = 0;
    bit e_we, e_full, e_pv, e_done;
    int e_na, e_np;

    int wq[$], pq[$], phq[$];
    int n_full, n_done, full_addr;

    function automatic int spd_key(input int s, input logic f, input logic sl);
        int r;
        r = s;
        if (f && !sl && s < MF - 1) r = s + 1;
        if (sl && !f && s > -(MF - 1)) r = s - 1;
        return r;
    endfunction

    task automatic model_comb();
        int mag;
        mag    = (m_spd < 0) ? -m_spd : m_spd;
        e_we   = rst_n && (m_st == C_RREC) && rec_valid;
        e_full = e_we && (m_raddr == DEPTH - 1);
        e_pv   = rst_n && (m_st == C_PPLAY) && play_req;
        if (m_spd > 0) begin
            e_na = m_paddr + m_spd + 1;
            e_np = 0;
        end else if (m_spd == 0 || m_ph >= mag) begin
            e_na = m_paddr + 1;
            e_np = 0;
        end else begin
            e_na = m_paddr;
            e_np = m_ph + 1;
        end
        e_done = e_pv && (e_na >= m_rlen);
    endtask

    task automatic model_seq();
        int nst;
        if (!rst_n) begin
            m_st = C_INIT; m_spd = 0; m_raddr = 0; m_rlen = 0; m_paddr = 0; m_ph = 0;
        end else begin
            nst = m_st;
            if (e_pv) begin
                m_paddr = e_done ? 0 : e_na;
                m_ph    = e_done ? 0 : e_np;
            end
            if (stop && m_st != C_INIT) begin
                m_paddr = 0;
                m_ph    = 0;
            end
            case (m_st)
                C_INIT:   if (init_done) nst = mode ? C_RSTOP : C_PSTOP;
                C_PSTOP: begin
                    if (mode) nst = C_RSTOP;
                    else if (!stop) begin
                        if (play_rec) begin
                            if (m_rlen > 0) nst = C_PPLAY;
                        end else m_spd = spd_key(m_spd, fast, slow);
                    end
                end
                C_PPLAY: begin
                    if (stop || e_done) nst = C_PSTOP;
                    else if (play_rec) nst = C_PPAUSE;
                    else m_spd = spd_key(m_spd, fast, slow);
                end
                C_PPAUSE: begin
                    if (stop) nst = C_PSTOP;
                    else if (play_rec) nst = C_PPLAY;
                    else m_spd = spd_key(m_spd, fast, slow);
                end
                C_RSTOP: begin
                    if (!mode) nst = C_PSTOP;
                    else if (!stop && play_rec) nst = C_RREC;
                end
                C_RREC: begin
                    m_raddr += int'(e_we);
                    if (e_full || stop) begin
                        m_rlen = m_raddr; m_raddr = 0; nst = C_RSTOP;
                    end else if (play_rec) nst = C_RPAUSE;
                end
                C_RPAUSE: begin
                    if (stop) begin
                        m_rlen = m_raddr; m_raddr = 0; nst = C_RSTOP;
                    end else if (play_rec) nst = C_RREC;
                end
                default: nst = C_INIT;
            endcase
            if (nst >= C_RSTOP || (nst == C_PSTOP && m_st != C_PSTOP)) m_spd = 0;
            m_st = nst;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_comb();
        chk("state",      o_state,           m_st);
        chk("speed_fast", o_speed_fast,      m_spd > 0);
        chk("speed_mag",  o_speed_mag,       (m_spd < 0) ? -m_spd : m_spd);
        chk("rec_addr",   o_rec_addr,        m_raddr);
        chk("rec_len",    o_rec_len,         m_rlen);
        chk("play_addr",  o_play_addr,       m_paddr);
        chk("play_phase", o_play_phase,      m_ph);
        chk("rec_we",     o_rec_we,          e_we);
        chk("full",       o_full,            e_full);
        chk("play_valid", o_play_addr_valid, e_pv);
        chk("play_done",  o_play_done,       e_done);
        if (o_rec_we === 1'b1) wq.push_back(int'(o_rec_addr));
        if (o_play_addr_valid === 1'b1) begin
            pq.push_back(int'(o_play_addr));
            phq.push_back(int'(o_play_phase));
        end
        if (o_full === 1'b1) begin
            n_full++;
            full_addr = int'(o_rec_addr);
        end
        if (o_play_done === 1'b1) n_done++;
        @(posedge clk);
        model_seq();
        #1;
        play_rec = 1'b0; stop = 1'b0; fast = 1'b0; slow = 1'b0;
        rec_valid = 1'b0; play_req = 1'b0;
    endtask

    task automatic record_words(input int n);
        play_rec = 1'b1;
        cyc();
        wq.delete();
        for (int i = 0; i < n; i++) begin
            rec_valid = 1'b1;
            cyc();
        end
        stop = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; init_done = 1'b1; mode = 1'b1;
        play_rec = 1'b0; stop = 1'b0; fast = 1'b0; slow = 1'b0;
        rec_valid = 1'b0; play_req = 1'b0;
        n_full = 0; n_done = 0; full_addr = -1;

        // Reset then init into the record side
        repeat (3) cyc();
        chk("t1_init_state", o_state, 3'b101);
        rst_n = 1'b1;
        cyc();
        chk("t1_rstop", o_state, 3'b100);
        chk("t1_rec_len", o_rec_len, 0);

        // Ten-word recording
        record_words(10);
        chk("t2_nwr", wq.size(), 10);
        for (int i = 0; i < wq.size() && i < 10; i++) chk("t2_waddr", wq[i], i);
        chk("t2_rec_len", o_rec_len, 10);
        chk("t2_state", o_state, 3'b100);

        // Record until memory full
        play_rec = 1'b1;
        cyc();
        wq.delete(); n_full = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rec_valid = 1'b1;
            cyc();
        end
        chk("t3_nwr", wq.size(), DEPTH);
        chk("t3_nfull", n_full, 1);
        chk("t3_full_addr", full_addr, DEPTH - 1);
        chk("t3_state", o_state, 3'b100);
        chk("t3_rec_len", o_rec_len, DEPTH);

        // x3 playback of a ten-word recording
        record_words(10);
        mode = 1'b0;
        cyc();
        chk("t4_pstop", o_state, 3'b000);
        play_rec = 1'b1; cyc();
        fast = 1'b1; cyc();
        fast = 1'b1; cyc();
        chk("t4_fast", o_speed_fast, 1);
        chk("t4_mag", o_speed_mag, 2);
        pq.delete(); n_done = 0;
        for (int i = 0; i < 6; i++) begin
            play_req = 1'b1;
            cyc();
        end
        chk("t4_nreq", pq.size(), 4);
        for (int i = 0; i < pq.size() && i < 4; i++) chk("t4_paddr", pq[i], 3 * i);
        chk("t4_ndone", n_done, 1);
        chk("t4_state", o_state, 3'b000);
        chk("t4_x1", o_speed_mag, 0);

        // Slow saturation and repeat phases
        play_rec = 1'b1; cyc();
        for (int i = 0; i < 9; i++) begin
            slow = 1'b1;
            cyc();
        end
        chk("t5_fast", o_speed_fast, 0);
        chk("t5_mag", o_speed_mag, 7);
        pq.delete(); phq.delete();
        for (int i = 0; i < 9; i++) begin
            play_req = 1'b1;
            cyc();
        end
        chk("t5_nreq", pq.size(), 9);
        for (int i = 0; i < pq.size() && i < 9; i++) begin
            chk("t5_paddr", pq[i], (i < 8) ? 0 : 1);
            chk("t5_phase", phq[i], (i < 8) ? i : 0);
        end
        fast = 1'b1; cyc();
        chk("t5_mag_dec", o_speed_mag, 6);

        // Key priority, pause hold, cancelling speed keys
        stop = 1'b1; play_rec = 1'b1; cyc();
        chk("t6_stop_state", o_state, 3'b000);
        chk("t6_stop_addr", o_play_addr, 0);
        play_rec = 1'b1; cyc();
        play_req = 1'b1; cyc();
        play_req = 1'b1; cyc();
        play_rec = 1'b1; cyc();
        chk("t6_pause", o_state, 3'b011);
        pq.delete();
        for (int i = 0; i < 3; i++) begin
            play_req = 1'b1;
            cyc();
        end
        chk("t6_pause_noreq", pq.size(), 0);
        chk("t6_pause_addr", o_play_addr, 2);
        fast = 1'b1; cyc();
        fast = 1'b1; slow = 1'b1; cyc();
        chk("t6_both_fast", o_speed_fast, 1);
        chk("t6_both_mag", o_speed_mag, 1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            init_done = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            stop      = ($urandom_range(0, 24) == 0);
            play_rec  = ($urandom_range(0, 9) == 0);
            fast      = ($urandom_range(0, 7) == 0);
            slow      = ($urandom_range(0, 7) == 0);
            rec_valid = 1'($urandom_range(0, 1));
            play_req  = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/transport_ctrl.md
Name: transport_ctrl

Overview:
Parametrised record/playback transport controller for the audio recorder: owns the top-level transport FSM, variable play speed, and record/play SRAM address generation. Sits between user IO (debounced single-cycle key pulses) and the SRAM controller, I2S, and DSP blocks. It adds the following to the fixed-width top-level control:
- a configurable speed range,
- record-length tracking,
- end-of-memory and end-of-recording handling,
- slow-mode repeat phase for the DSP interpolator.

Parameters:
- ADDR_W, 20: SRAM word address width.
- MAX_FACTOR, 8: largest speed-up and slow-down factor, 2..16.
- SPD_W, 4: width of speed magnitude; must satisfy 2^SPD_W >= MAX_FACTOR.

Ports:
- i_clk, in, 1: system clock.
- i_rst_n, in, 1: synchronous active-low reset.
- i_init_done, in, 1: codec/I2C init finished.
- i_mode, in, 1: 1 = record side, 0 = play side.
- i_play_rec, in, 1: pulse; start or pause/resume.
- i_stop, in, 1: pulse; stop.
- i_fast, in, 1: pulse; speed up.
- i_slow, in, 1: pulse; slow down.
- i_rec_valid, in, 1: record sample accepted from I2S.
- i_play_req, in, 1: DSP requests the next play sample.
- o_state, out, 3: transport state code.
- o_speed_fast, out, 1: 1 = faster than x1.
- o_speed_mag, out, SPD_W: factor-1 (0 = x1).
- o_rec_addr, out, ADDR_W: current write address.
- o_rec_we, out, 1: write strobe to SRAM controller.
- o_play_addr, out, ADDR_W: current read address.
- o_play_addr_valid, out, 1: read address issued.
- o_play_phase, out, SPD_W: repeat index in slow mode.
- o_rec_len, out, ADDR_W+1: recorded length in words.
- o_full, out, 1: pulse; memory exhausted.
- o_play_done, out, 1: pulse; end of recording reached.

Behaviour:
- Clocking and reset: all state is on the i_clk rising edge. Reset is synchronous and active-low on i_rst_n. While i_rst_n is low:
  - state = INIT, speed = x1 (fast=0, mag=0);
  - addresses, phase and o_rec_len = 0;
  - all strobes = 0.
  Reset mid-record discards the recording (o_rec_len = 0).
- State codes: INIT=101, P_STOP=000, P_PLAY=010, P_PAUSE=011, R_STOP=100, R_REC=110, R_PAUSE=111.
- INIT: when i_init_done=1, go to R_STOP if i_mode=1, else P_STOP.
- Mode switch: only in P_STOP/R_STOP. i_mode is sampled each cycle; the state follows i_mode on the next cycle.
- Key priority per cycle: stop > play_rec > fast/slow. i_fast and i_slow together are ignored.
- Stop key (i_stop) in any non-INIT state:
  - go to the STOP of the same side;
  - o_play_addr = 0 and phase = 0;
  - leaving R_REC/R_PAUSE latches o_rec_len = o_rec_addr, then clears o_rec_addr.
- Play/record key (i_play_rec):
  - STOP -> PLAY/REC;
  - PLAY <-> PAUSE and REC <-> PAUSE;
  - P_STOP with o_rec_len = 0 stays in P_STOP.
- Recording, in R_REC only:
  - i_rec_valid -> o_rec_we = 1 in the same cycle, with o_rec_addr as the address;
  - o_rec_addr increments on the next cycle.
  - On a write at address 2^ADDR_W-1: o_full pulses for 1 cycle, o_rec_len = 2^ADDR_W, and the next state is R_STOP.
  - i_rec_valid outside R_REC is ignored.
- Speed:
  - Forced to x1 in all record states, INIT, and on entry to P_STOP.
  - Fast from x1 -> fast mag 1 (x2). Fast mag saturates at MAX_FACTOR-1.
  - Slow from x1 -> slow mag 1 (x1/2). Slow mag saturates at MAX_FACTOR-1.
  - Fast while in slow decrements the slow mag; slow while in fast decrements the fast mag. Either reaches x1 at mag 0.
  - Speed changes take effect on the next i_play_req.
- Playback, in P_PLAY only. On i_play_req, o_play_addr_valid = 1 for one cycle with the current o_play_addr and o_play_phase. Then:
  - x1: addr += 1.
  - fast: addr += mag+1, using an ADDR_W+1-bit sum.
  - slow: if phase == mag then phase = 0 and addr += 1; else phase += 1.
- End of recording: if the next addr >= o_rec_len, then o_play_done pulses, addr = 0, phase = 0, and the next state is P_STOP. The address never wraps.
- Pause: P_PAUSE holds addr/phase; i_play_req is ignored. R_PAUSE holds o_rec_addr.
- Latency: key pulse -> o_state change is 1 cycle. Strobes are combinational from the request inputs gated by the registered state.

Decomposition:
- Package transport_pkg holds:
  - typedef enum logic [2:0] state_t with the codes above;
  - the speed struct {fast, mag};
  - helper function next_speed(speed, fast, slow, MAX_FACTOR).
- One sub-module, play_addr_gen: speed-aware read-address/phase stepper with end detection. The FSM, record counter and speed register stay in transport_ctrl.

Test Plan:
1. Reset low 3 cycles, then high with i_init_done=1, i_mode=1 -> o_state 101 then 100; all outputs 0.
2. Record: i_play_rec, 10 i_rec_valid pulses, i_stop -> o_rec_we x10 at addresses 0..9; o_rec_len = 10; o_state 100.
3. Full: ADDR_W=4, record continuously -> 16 writes; o_full pulse on the write at address 15; state 100; o_rec_len = 16.
4. Fast: o_rec_len=10, play, i_fast x2 (x3), then requests -> o_play_addr 0, 3, 6, 9; next step gives o_play_done; state 000.
5. Slow/saturation: i_slow x9 with MAX_FACTOR=8 -> mag 7. Requests -> addr 0 for phases 0..7, then addr 1. One i_fast -> mag 6.
6. Priority and pause: i_stop with i_play_rec in the same cycle during P_PLAY -> P_STOP, addr 0. In P_PAUSE, i_play_req is ignored and addr is held. i_fast with i_slow together -> speed unchanged.
